fetch_unit: RTL and testbench

//   IF-stage controller of the 5-stage MIPS pipeline. Owns the PC register and drives the instruction memory address.

---
 rtl/fetch_unit.sv | 61 ++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, computes next PC (seq / D-stage redirect),
// fills the IF/ID register, flags PC faults and counts fetches.
module fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter int unsigned IM_WORDS  = 4096,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr_in,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_LIMIT = PC_RESET + 32'(4 * IM_WORDS);

    logic        bad;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;

    always_comb begin
        bad      = (pc[1:0] != 2'b00) || (pc < PC_RESET) || (pc >= PC_LIMIT);
        pc_plus4 = pc + 32'd4;
        pc_plus8 = pc + 32'd8;
    end

    // Fault is sticky and freezes everything until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= PC_RESET;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= PC_RESET;
            if_id_pc8   <= PC_RESET + 32'd8;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_count <= 32'd0;
        end else if (fetch_fault) begin
            if_id_valid <= 1'b0;
        end else if (bad) begin
            fetch_fault <= 1'b1;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_instr <= instr_in;
            if_id_pc    <= pc;
            if_id_pc8   <= pc_plus8;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            pc          <= redirect ? redirect_pc : pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect
// traffic, checked every cycle against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam int unsigned IM_WORDS  = 4096;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_TOP    = PC_RESET + 32'(4 * IM_WORDS);

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_in;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc8;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;
    logic [31:0] salt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    fetch_unit #(
        .PC_RESET (PC_RESET),
        .IM_WORDS (IM_WORDS),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_in   (instr_in),
        .pc         (pc),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc8  (if_id_pc8),
        .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a,
                                             input logic [31:0] s);
        logic [31:0] idx;
        idx = (a - PC_RESET) >> 2;
        return {16'h2408, idx[15:0]} ^ s;
    endfunction

    always_comb instr_in = mem_word(pc, salt);

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Model state: the fetch stream as seen by decode.
    logic [31:0] m_pc    = PC_RESET;
    logic [31:0] m_instr = NOP_INSTR;
    logic [31:0] m_ipc   = PC_RESET;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_cnt   = 32'd0;

    function automatic bit pc_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a >= PC_RESET) && (a < PC_TOP);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_pc = PC_RESET; m_instr = NOP_INSTR; m_ipc = PC_RESET;
            m_valid = 0; m_fault = 0; m_cnt = 0;
        end else if (m_fault) begin
            m_valid = 0;
        end else if (!pc_ok(m_pc)) begin
            m_fault = 1; m_instr = NOP_INSTR; m_valid = 0;
        end else if (!stall) begin
            m_instr = mem_word(m_pc, salt);
            m_ipc   = m_pc;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            m_pc    = redirect ? redirect_pc : m_pc + 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("if_id_instr", if_id_instr, m_instr);
            check("if_id_pc", if_id_pc, m_ipc);
            check("if_id_pc8", if_id_pc8, m_ipc + 32'd8);
            check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
            check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            check("fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0; cyc(1); reset = 1;
    endtask

    initial begin
        reset = 0; stall = 0; redirect = 0;
        redirect_pc = 0; salt = 0;
        cyc(2);
        chk_en = 1;
        check("t1_pc", pc, 32'h3000);
        check("t1_valid", 32'(if_id_valid), 0);
        check("t1_count", fetch_count, 0);
        reset = 1;
        cyc(1);
        check("t1_ifpc", if_id_pc, 32'h3000);
        check("t1_pc8", if_id_pc8, 32'h3008);
        check("t1_valid1", 32'(if_id_valid), 1);
        check("t1_pc4", pc, 32'h3004);
        cyc(4);
        check("t2_pc", pc, 32'h3014);
        check("t2_count", fetch_count, 5);
        check("t2_instr", if_id_instr, 32'h2408_0004);
        check("t2_ifpc", if_id_pc, 32'h3010);

        do_reset(); cyc(2);
        check("t3_pc0", pc, 32'h3008);
        stall = 1; redirect = 1; redirect_pc = 32'h3040;
        cyc(3);
        check("t3_pc", pc, 32'h3008);
        check("t3_count", fetch_count, 2);
        check("t3_ifpc", if_id_pc, 32'h3004);
        stall = 0; redirect = 0;
        cyc(1);
        check("t3_next", pc, 32'h300C);

        redirect = 1; redirect_pc = 32'h3040;
        cyc(1);
        check("t4_slot", if_id_pc, 32'h300C);
        check("t4_pc", pc, 32'h3040);
        redirect = 0;
        cyc(1);
        check("t4_tgt", if_id_pc, 32'h3040);

        redirect = 1; redirect_pc = 32'h3002;
        cyc(1);
        check("t5_pc", pc, 32'h3002);
        redirect = 0;
        cyc(1);
        check("t5_fault", 32'(fetch_fault), 1);
        check("t5_valid", 32'(if_id_valid), 0);
        cyc(4);
        check("t5_frozen", pc, 32'h3002);
        check("t5_count", fetch_count, 6);
        do_reset();
        check("t5_clr", 32'(fetch_fault), 0);
        check("t5_rst", pc, 32'h3000);

        cyc(IM_WORDS);
        check("t6_ifpc", if_id_pc, 32'h6FFC);
        check("t6_instr", if_id_instr, 32'h2408_0FFF);
        check("t6_pc", pc, 32'h7000);
        cyc(1);
        check("t6_fault", 32'(fetch_fault), 1);
        check("t6_count", fetch_count, 4096);

        // Wrapping and below-range redirect targets.
        do_reset();
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        cyc(1); redirect = 0; cyc(1);
        check("wrap_fault", 32'(fetch_fault), 1);
        do_reset();
        redirect = 1; redirect_pc = PC_RESET - 4;
        cyc(1); redirect = 0; cyc(1);
        check("low_fault", 32'(fetch_fault), 1);

        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                salt     = $urandom;
                stall    = ($urandom_range(3) == 0);
                redirect = ($urandom_range(4) == 0);
                if ($urandom_range(19) == 0)
                    redirect_pc = $urandom;
                else
                    redirect_pc = PC_RESET +
                        4 * $urandom_range(IM_WORDS - 1);
                reset = ($urandom_range(49) != 0);
                cyc(1);
            end
        end
        reset = 1; stall = 0; redirect = 0;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
